wshb_slave_mem: RTL and testbench

WSHB_SLAVE_MEM -- requirements
Module: wshb_slave_mem

---
 rtl/wshb_if.sv | 29 ++
 rtl/wshb_slave_mem.sv | 210 +++++++++++++++++++++
 tb/tb_wshb_slave_mem.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with clock and synchronous active-high reset,
// plus master and slave views.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst, ack, err, rty, dat_sm,
    output cyc, stb, we, adr, sel, cti, bte, dat_ms
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, cti, bte, dat_ms,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/wshb_slave_mem.sv
// Wishbone slave backed by a single-port word memory with configurable wait states.
// Define WSHB_SLAVE_MEM_BURST_EN to enable linear incrementing bursts (cti=010, bte=00).
module wshb_slave_mem #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADR    = 32'h0
) (
  wshb_if.slave wshb_ifs
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IdxOne = 1;
  localparam logic [2:0] CtiIncr = 3'b010;

`ifdef WSHB_SLAVE_MEM_BURST_EN
  typedef enum logic [1:0] {StIdle, StWait, StAck, StBurst} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;
`endif

  logic clk;
  logic rst;
  assign clk = wshb_ifs.clk;
  assign rst = wshb_ifs.rst;

  state_e state_q, state_d;

  logic [31:0] mem [Depth];

  logic [2:0]            cnt_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  bad_q;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           dat_q;
`ifdef WSHB_SLAVE_MEM_BURST_EN
  logic [2:0]            cti_q;
  logic [1:0]            bte_q;
`endif

  logic                  start;
  logic [31:0]           offset;
  logic                  req_bad;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  mem_we;
  logic                  rd_en;
  logic                  beat;
  logic [3:0]            mem_sel;

  assign offset  = wshb_ifs.adr - BASE_ADR;
  assign req_idx = offset[DEPTH_LOG2+1:2];
  // A request still held during the response cycle is the one just answered.
  assign start   = wshb_ifs.cyc & wshb_ifs.stb & ~ack_q & ~err_q;

  always_comb begin
    req_bad = (wshb_ifs.adr < BASE_ADR) || ((offset[31:2] >> DEPTH_LOG2) != 30'd0);
`ifdef WSHB_SLAVE_MEM_BURST_EN
    if (wshb_ifs.cti == CtiIncr && wshb_ifs.bte != 2'b00) begin
      req_bad = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (WAIT_STATES > 0) ? StWait : StAck;
        end
      end
      StWait: begin
        if (!wshb_ifs.cyc) begin
          state_d = StIdle;
        end else if (cnt_q <= 3'd1) begin
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
`ifdef WSHB_SLAVE_MEM_BURST_EN
        if (wshb_ifs.cyc && !bad_q && cti_q == CtiIncr && bte_q == 2'b00) begin
          state_d = StBurst;
        end
`endif
      end
`ifdef WSHB_SLAVE_MEM_BURST_EN
      StBurst: begin
        if (!wshb_ifs.cyc) begin
          state_d = StIdle;
        end else if (wshb_ifs.stb && wshb_ifs.cti != CtiIncr) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath control
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    rd_en   = 1'b0;
    beat    = 1'b0;
    mem_sel = sel_q;
    case (state_q)
      StAck: begin
        if (wshb_ifs.cyc) begin
          if (bad_q) begin
            err_d = 1'b1;
          end else begin
            ack_d  = 1'b1;
            mem_we = we_q;
            rd_en  = ~we_q;
            beat   = 1'b1;
          end
        end
      end
`ifdef WSHB_SLAVE_MEM_BURST_EN
      StBurst: begin
        if (wshb_ifs.cyc && wshb_ifs.stb) begin
          ack_d   = 1'b1;
          mem_we  = we_q;
          rd_en   = ~we_q;
          beat    = 1'b1;
          mem_sel = wshb_ifs.sel;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
      we_q  <= 1'b0;
      sel_q <= 4'd0;
      idx_q <= '0;
      bad_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= 32'd0;
`ifdef WSHB_SLAVE_MEM_BURST_EN
      cti_q <= 3'd0;
      bte_q <= 2'd0;
`endif
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= rd_en ? mem[idx_q] : 32'd0;
      if (state_q == StIdle && start) begin
        cnt_q <= 3'(WAIT_STATES);
        we_q  <= wshb_ifs.we;
        sel_q <= wshb_ifs.sel;
        idx_q <= req_idx;
        bad_q <= req_bad;
`ifdef WSHB_SLAVE_MEM_BURST_EN
        cti_q <= wshb_ifs.cti;
        bte_q <= wshb_ifs.bte;
`endif
      end else if (state_q == StWait && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
`ifdef WSHB_SLAVE_MEM_BURST_EN
      if (beat) begin
        idx_q <= idx_q + IdxOne;
      end
`endif
    end
  end

  // Memory has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_sel[b]) begin
          mem[idx_q][8*b +: 8] <= wshb_ifs.dat_ms[8*b +: 8];
        end
      end
    end
  end

  assign wshb_ifs.ack    = ack_q;
  assign wshb_ifs.err    = err_q;
  assign wshb_ifs.rty    = 1'b0;
  assign wshb_ifs.dat_sm = dat_q;

  logic unused_bits;
`ifdef WSHB_SLAVE_MEM_BURST_EN
  assign unused_bits = ^{offset[1:0], beat};
`else
  assign unused_bits = ^{offset[1:0], beat, wshb_ifs.cti, wshb_ifs.bte};
`endif

endmodule

// File: tb/tb_wshb_slave_mem.sv
// Directed bench for wshb_slave_mem: one instance with one wait state and one with two,
// sharing the master-side signals and selected by tgt.
module tb_wshb_slave_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        tgt, cyc, stb, we;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int n_cmp = 0;
  int n_err = 0;

  wshb_if bus1 (.clk(clk), .rst(rst));
  wshb_if bus2 (.clk(clk), .rst(rst));

  assign bus1.cyc    = cyc & ~tgt;
  assign bus1.stb    = stb & ~tgt;
  assign bus1.we     = we;
  assign bus1.adr    = adr;
  assign bus1.sel    = sel;
  assign bus1.cti    = cti;
  assign bus1.bte    = bte;
  assign bus1.dat_ms = dat_ms;
  assign bus2.cyc    = cyc & tgt;
  assign bus2.stb    = stb & tgt;
  assign bus2.we     = we;
  assign bus2.adr    = adr;
  assign bus2.sel    = sel;
  assign bus2.cti    = cti;
  assign bus2.bte    = bte;
  assign bus2.dat_ms = dat_ms;

  wshb_slave_mem #(.DEPTH_LOG2(10), .WAIT_STATES(1), .BASE_ADR(32'h0)) dut1 (.wshb_ifs(bus1));
  wshb_slave_mem #(.DEPTH_LOG2(10), .WAIT_STATES(2), .BASE_ADR(32'h0)) dut2 (.wshb_ifs(bus2));

  logic        ack_o, err_o, rty_o;
  logic [31:0] dat_o;
  assign ack_o = tgt ? bus2.ack : bus1.ack;
  assign err_o = tgt ? bus2.err : bus1.err;
  assign rty_o = tgt ? bus2.rty : bus1.rty;
  assign dat_o = tgt ? bus2.dat_sm : bus1.dat_sm;

  logic [31:0] r;
  logic        a, e;
  int          l;
  logic        seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Classic single transfer; waits (bounded) for ack or err, then releases the bus.
  task automatic xfer(input logic b, input logic w, input logic [31:0] ad, input logic [3:0] s,
                      input logic [31:0] d, input logic [2:0] c, input logic [1:0] t,
                      output logic [31:0] rd, output logic ak, output logic er, output int lat);
    tgt = b; we = w; adr = ad; sel = s; dat_ms = d; cti = c; bte = t;
    cyc = 1'b1; stb = 1'b1;
    lat = 0; ak = 1'b0; er = 1'b0; rd = 32'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (ack_o || err_o) begin
        ak = ack_o; er = err_o; rd = dat_o;
        chk("rty_low", rty_o, 0);
        break;
      end
    end
    chk("xfer_done", ak | er, 1);
    chk("ack_err_excl", ak & er, 0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    tick();
    chk("post_ack_low", ack_o, 0);
    chk("post_dat_zero", dat_o, 0);
  endtask

  task automatic wr(input logic b, input logic [31:0] ad, input logic [31:0] d);
    logic [31:0] rr; logic ak, er; int lt;
    xfer(b, 1'b1, ad, 4'hF, d, 3'b000, 2'b00, rr, ak, er, lt);
    chk("wr_ack", ak, 1);
  endtask

  initial begin
    tgt = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; dat_ms = 32'd0;
    sel = 4'd0; cti = 3'd0; bte = 2'd0; rst = 1'b1;
    repeat (3) tick();
    chk("rst_ack1", bus1.ack, 0);
    chk("rst_err1", bus1.err, 0);
    chk("rst_rty1", bus1.rty, 0);
    chk("rst_dat1", bus1.dat_sm, 0);
    chk("rst_ack2", bus2.ack, 0);
    rst = 1'b0;
    tick();

    // Cycle-exact write on the one-wait-state instance: ack only after edge 2.
    tgt = 1'b0; we = 1'b1; adr = 32'h10; sel = 4'hF; dat_ms = 32'hDEADBEEF;
    cyc = 1'b1; stb = 1'b1;
    tick(); chk("wr_e0_ack", ack_o, 0);
    tick(); chk("wr_e1_ack", ack_o, 0);
    tick(); chk("wr_e2_ack", ack_o, 1); chk("wr_e2_err", err_o, 0);
    cyc = 1'b0; stb = 1'b0;
    tick(); chk("wr_e3_ack", ack_o, 0);

    xfer(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("rd10_ack", a, 1); chk("rd10_dat", r, 32'hDEADBEEF); chk("rd10_lat", l, 3);

    // Byte-enable merge.
    xfer(1'b0, 1'b1, 32'h10, 4'b0101, 32'h11223344, 3'b000, 2'b00, r, a, e, l);
    xfer(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("merge_dat", r, 32'hDE22BE44);

    // Last in-range word, then the first out-of-range word.
    wr(1'b0, 32'hFFC, 32'hCAFEF00D);
    xfer(1'b0, 1'b0, 32'hFFE, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("top_ack", a, 1); chk("top_dat", r, 32'hCAFEF00D);
    xfer(1'b0, 1'b0, 32'h1000, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("oor_err", e, 1); chk("oor_ack", a, 0); chk("oor_dat", r, 0);
    xfer(1'b0, 1'b1, 32'h1004, 4'hF, 32'h12345678, 3'b000, 2'b00, r, a, e, l);
    chk("oor_wr_err", e, 1);
    xfer(1'b0, 1'b0, 32'h4, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("alias_ack", a, 1);

    // Reset in the wait state of a write: no ack, memory untouched.
    tgt = 1'b0; we = 1'b1; adr = 32'h10; sel = 4'hF; dat_ms = 32'h0BADF00D;
    cyc = 1'b1; stb = 1'b1;
    tick();
    rst = 1'b1;
    tick(); chk("rstw_ack", ack_o, 0); chk("rstw_err", err_o, 0); chk("rstw_dat", dat_o, 0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick(); chk("rstw_ack2", ack_o, 0);
    tick(); chk("rstw_ack3", ack_o, 0);
    xfer(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("rstw_mem", r, 32'hDE22BE44);

    // cyc dropped while waiting aborts the write.
    wr(1'b0, 32'h14, 32'h55AA55AA);
    tgt = 1'b0; we = 1'b1; adr = 32'h14; sel = 4'hF; dat_ms = 32'h77777777;
    cyc = 1'b1; stb = 1'b1;
    tick();
    cyc = 1'b0; stb = 1'b0;
    tick(); chk("abort_ack1", ack_o, 0);
    tick(); chk("abort_ack2", ack_o, 0);
    xfer(1'b0, 1'b0, 32'h14, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("abort_mem", r, 32'h55AA55AA);

    // Two-wait-state instance: preload mem[8..11] and mem[16..19].
    for (int i = 0; i < 4; i++) begin
      wr(1'b1, 32'h20 + 32'(4 * i), 32'hA0000000 + 32'(i));
      wr(1'b1, 32'h40 + 32'(4 * i), 32'hB0000000 + 32'(i));
    end
    xfer(1'b1, 1'b0, 32'h24, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("ws2_lat", l, 4); chk("ws2_dat", r, 32'hA0000001);

`ifdef WSHB_SLAVE_MEM_BURST_EN
    // Four-beat incrementing read burst: acks at edges 3,4,5,6.
    tgt = 1'b1; we = 1'b0; adr = 32'h20; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    l = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      l++;
      if (ack_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("burst_first_seen", seen, 1); chk("burst_first_lat", l, 4);
    chk("burst_beat0", dat_o, 32'hA0000000);
    tick(); chk("burst_ack1", ack_o, 1); chk("burst_beat1", dat_o, 32'hA0000001);
    tick(); chk("burst_ack2", ack_o, 1); chk("burst_beat2", dat_o, 32'hA0000002);
    cti = 3'b111;
    tick(); chk("burst_ack3", ack_o, 1); chk("burst_beat3", dat_o, 32'hA0000003);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    tick(); chk("burst_end_ack", ack_o, 0); chk("burst_end_dat", dat_o, 0);

    // Wrapping burst type is refused.
    xfer(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 3'b010, 2'b01, r, a, e, l);
    chk("bte_err", e, 1); chk("bte_ack", a, 0);

    // Write burst abandoned after two beats.
    tgt = 1'b1; we = 1'b1; adr = 32'h40; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    dat_ms = 32'hC0000000; cyc = 1'b1; stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wburst_seen", seen, 1);
    dat_ms = 32'hC0000001;
    tick(); chk("wburst_ack1", ack_o, 1);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    tick(); chk("wburst_drop_ack", ack_o, 0);
    xfer(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("wburst_m16", r, 32'hC0000000);
    xfer(1'b1, 1'b0, 32'h44, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("wburst_m17", r, 32'hC0000001);
    xfer(1'b1, 1'b0, 32'h48, 4'hF, 32'h0, 3'b000, 2'b00, r, a, e, l);
    chk("wburst_m18", r, 32'hB0000002);
`else
    // Without bursts every beat is a classic transfer with full latency.
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b0, 32'h20 + 32'(4 * i), 4'hF, 32'h0, (i == 3) ? 3'b111 : 3'b010, 2'b00,
           r, a, e, l);
      chk("cburst_ack", a, 1);
      chk("cburst_lat", l, 4);
      chk("cburst_dat", r, 32'hA0000000 + 32'(i));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
